// File: rtl/ro_meas_pkg.sv
// ============================================================================
// Module   : ro_meas_pkg
// Purpose  : Shared types and constants for the ring-oscillator measurement
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ro_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_GATE   = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  localparam int SETTLE_CYC  = 4;
  localparam int NUM_SRC     = 8;
  localparam int SYNC_STAGES = 2;
  localparam int SRC_W       = $clog2(NUM_SRC);

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ro_meas_edge_cnt.sv
// ============================================================================
// Module   : ro_meas_edge_cnt
// Purpose  : Synchronises the oscillator output, detects rising edges and
//            counts them with saturation and an overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_meas_edge_cnt
  import ro_meas_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             osc_in,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   rise;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], osc_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en && rise) begin
      // At full scale an edge is dropped and flagged instead of wrapping.
      if (&count_q) ovf_d   = 1'b1;
      else          count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/ro_meas_ctrl.sv
// ============================================================================
// Module   : ro_meas_ctrl
// Purpose  : Loads the oscillator config shifter, gates and counts the
//            selected oscillator, returns the count over valid/ready.
//            Optional: RO_MEAS_SWEEP_EN enables an all-source sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int CFG_W     = 12,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16,
  parameter int SHIFT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sweep,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [SRC_W-1:0] src_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic             osc_in,
  output logic             shift_clk,
  output logic             shift_dta,
  output logic [SRC_W-1:0] clk_source,
  output logic             osc_ena,
  output logic             osc_rst,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [SRC_W-1:0] res_src,
  output logic             res_ovf
);

  localparam int BIT_W = cnt_width(CFG_W);
  localparam int DIV_W = cnt_width(SHIFT_DIV);
  localparam int SET_W = cnt_width(SETTLE_CYC);

  state_e           state_q, state_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] gcnt_q, gcnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             half_q, half_d;
  logic             shift_clk_q, shift_clk_d;
  logic             shift_dta_q, shift_dta_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             osc_ena_q, osc_ena_d;
  logic             osc_rst_q, osc_rst_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [SRC_W-1:0] res_src_q, res_src_d;
`ifdef RO_MEAS_SWEEP_EN
  logic             sweep_q, sweep_d;
`else
  logic             unused_sweep;
  assign unused_sweep = sweep;
`endif

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    win_d       = win_q;
    gcnt_d      = gcnt_q;
    bit_d       = bit_q;
    div_d       = div_q;
    set_d       = set_q;
    half_d      = half_q;
    shift_clk_d = shift_clk_q;
    shift_dta_d = shift_dta_q;
    src_d       = src_q;
    osc_ena_d   = osc_ena_q;
    osc_rst_d   = osc_rst_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    res_src_d   = res_src_q;
`ifdef RO_MEAS_SWEEP_EN
    sweep_d     = sweep_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SHIFT;
          busy_d      = 1'b1;
          cfg_d       = cfg_word;
          win_d       = (win_len == '0) ? WIN_W'(1) : win_len;
          bit_d       = BIT_W'(CFG_W - 1);
          div_d       = '0;
          half_d      = 1'b0;
          shift_clk_d = 1'b0;
          shift_dta_d = cfg_word[CFG_W-1];
`ifdef RO_MEAS_SWEEP_EN
          sweep_d     = sweep;
          src_d       = sweep ? '0 : src_sel;
`else
          src_d       = src_sel;
`endif
        end
      end
      ST_SHIFT: begin
        // Each bit: SHIFT_DIV cycles with shift_clk low, then SHIFT_DIV high.
        if (div_q == DIV_W'(SHIFT_DIV - 1)) begin
          div_d = '0;
          if (!half_q) begin
            half_d      = 1'b1;
            shift_clk_d = 1'b1;
          end else begin
            half_d      = 1'b0;
            shift_clk_d = 1'b0;
            if (bit_q == '0) begin
              state_d   = ST_SETTLE;
              set_d     = '0;
              osc_ena_d = 1'b1;
              osc_rst_d = 1'b1;
            end else begin
              bit_d       = bit_q - BIT_W'(1);
              shift_dta_d = cfg_q[bit_q - BIT_W'(1)];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d   = ST_GATE;
          osc_rst_d = 1'b0;
          gcnt_d    = '0;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      ST_GATE: begin
        if (gcnt_q == win_q - WIN_W'(1)) begin
          state_d     = ST_RESULT;
          osc_ena_d   = 1'b0;
          osc_rst_d   = 1'b1;
          res_valid_d = 1'b1;
          res_src_d   = src_q;
        end else begin
          gcnt_d = gcnt_q + WIN_W'(1);
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
`ifdef RO_MEAS_SWEEP_EN
          if (sweep_q && (src_q != SRC_W'(NUM_SRC - 1))) begin
            state_d   = ST_SETTLE;
            src_d     = src_q + SRC_W'(1);
            set_d     = '0;
            osc_ena_d = 1'b1;
            osc_rst_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      win_q       <= '0;
      gcnt_q      <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      set_q       <= '0;
      half_q      <= 1'b0;
      shift_clk_q <= 1'b0;
      shift_dta_q <= 1'b0;
      src_q       <= '0;
      osc_ena_q   <= 1'b0;
      osc_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_src_q   <= '0;
`ifdef RO_MEAS_SWEEP_EN
      sweep_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      win_q       <= win_d;
      gcnt_q      <= gcnt_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      set_q       <= set_d;
      half_q      <= half_d;
      shift_clk_q <= shift_clk_d;
      shift_dta_q <= shift_dta_d;
      src_q       <= src_d;
      osc_ena_q   <= osc_ena_d;
      osc_rst_q   <= osc_rst_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
`ifdef RO_MEAS_SWEEP_EN
      sweep_q     <= sweep_d;
`endif
    end
  end

  // Count is cleared through SETTLE and frozen outside GATE, so it holds in RESULT.
  ro_meas_edge_cnt #(
    .CNT_W (CNT_W)
  ) u_edge_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_SETTLE),
    .en     (state_q == ST_GATE),
    .osc_in (osc_in),
    .count  (res_count),
    .ovf    (res_ovf)
  );

  assign shift_clk  = shift_clk_q;
  assign shift_dta  = shift_dta_q;
  assign clk_source = src_q;
  assign osc_ena    = osc_ena_q;
  assign osc_rst    = osc_rst_q;
  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign res_src    = res_src_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_meas_ctrl.sv
// ============================================================================
// Module   : tb_ro_meas_ctrl
// Purpose  : Self-checking bench for ro_meas_ctrl (16-bit and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ro_meas_ctrl;

  localparam int CFG_W     = 12;
  localparam int SHIFT_DIV = 4;
  localparam int SHIFT_CYC = 2 * CFG_W * SHIFT_DIV;
  localparam int HIST      = 65536;
`ifdef RO_MEAS_SWEEP_EN
  localparam bit SWEEP_BUILD = 1'b1;
`else
  localparam bit SWEEP_BUILD = 1'b0;
`endif

  logic        clk;
  logic        rst, start, sweep, osc_in, res_ready;
  logic [11:0] cfg_word;
  logic [2:0]  src_sel;
  logic [15:0] win_len;

  logic        shift_clk, shift_dta, osc_ena, osc_rst, busy, res_valid, res_ovf;
  logic [2:0]  clk_source, res_src;
  logic [15:0] res_count;

  logic        unused4_shift_clk, unused4_shift_dta, unused4_osc_ena, unused4_osc_rst;
  logic        unused4_busy, unused4_res_valid, res_ovf4;
  logic [2:0]  unused4_clk_source, unused4_res_src;
  logic [3:0]  res_count4;

  ro_meas_ctrl #(.CFG_W(12), .CNT_W(16), .WIN_W(16), .SHIFT_DIV(SHIFT_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .sweep(sweep), .cfg_word(cfg_word),
    .src_sel(src_sel), .win_len(win_len), .osc_in(osc_in),
    .shift_clk(shift_clk), .shift_dta(shift_dta), .clk_source(clk_source),
    .osc_ena(osc_ena), .osc_rst(osc_rst), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_count(res_count), .res_src(res_src), .res_ovf(res_ovf)
  );

  ro_meas_ctrl #(.CFG_W(12), .CNT_W(4), .WIN_W(16), .SHIFT_DIV(SHIFT_DIV)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sweep(sweep), .cfg_word(cfg_word),
    .src_sel(src_sel), .win_len(win_len), .osc_in(osc_in),
    .shift_clk(unused4_shift_clk), .shift_dta(unused4_shift_dta),
    .clk_source(unused4_clk_source), .osc_ena(unused4_osc_ena),
    .osc_rst(unused4_osc_rst), .busy(unused4_busy), .res_valid(unused4_res_valid),
    .res_ready(res_ready), .res_count(res_count4), .res_src(unused4_res_src),
    .res_ovf(res_ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int osc_half = 0;
  bit osc_rand = 1'b0;
  int tog_cnt = 0;
  bit osc_hist [HIST];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance one clock; inputs for the new cycle (including osc_in) are set here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HIST) begin
      $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, HIST);
      $fatal(1, "cycle budget exhausted");
    end
    if (osc_rand) begin
      osc_in = 1'($urandom_range(0, 1));
    end else if (osc_half > 0) begin
      tog_cnt++;
      if (tog_cnt >= osc_half) begin
        osc_in  = ~osc_in;
        tog_cnt = 0;
      end
    end
    osc_hist[cyc] = osc_in;
  endtask

  task automatic set_osc(input int half, input bit rnd);
    osc_half = half;
    osc_rand = rnd;
    tog_cnt  = 0;
    if (half == 0 && !rnd) osc_in = 1'b0;
  endtask

  // Rising edges of the sampled oscillator whose first-high cycle lies in [lo, hi].
  function automatic int rises(input int lo, input int hi);
    int n = 0;
    for (int r = lo; r <= hi; r++)
      if (r > 0 && osc_hist[r] && !osc_hist[r-1]) n++;
    return n;
  endfunction

  task automatic run_meas(input logic [11:0] cfg, input logic [2:0] src, input logic [15:0] win,
                          input bit do_sweep, input int rdy_delay,
                          input bit use_rng, input int lo, input int hi, input bit exp_ovf4);
    int weff, nres, pulses, hi_cyc, ena_cyc, rlow_cyc, src_bad, v_bad, st_bad, p, tv, n, t;
    logic [11:0] sh;
    logic        prev_sclk;
    logic [2:0]  rsrc;
    logic [15:0] e16;
    logic [3:0]  e4;
    weff = (win == 16'd0) ? 1 : int'(win);
    nres = (do_sweep && SWEEP_BUILD) ? 8 : 1;
    t = cyc;
    chk("idle_busy", busy, 0);
    start = 1'b1; sweep = do_sweep; cfg_word = cfg; src_sel = src; win_len = win;
    res_ready = (rdy_delay == 0);
    tick();
    start = 1'b0; sweep = 1'b0;
    cfg_word = 12'($urandom); src_sel = 3'($urandom); win_len = 16'($urandom);
    chk("busy_rise", busy, 1);
    pulses = 0; hi_cyc = 0; ena_cyc = 0; rlow_cyc = 0; src_bad = 0; v_bad = 0;
    sh = '0; prev_sclk = 1'b0;
    rsrc = (nres > 1) ? 3'd0 : src;
    p = t + 1 + SHIFT_CYC;
    for (int k = 0; k < nres; k++) begin
      tv = p + 4 + weff;
      while (cyc < tv) begin
        if (shift_clk && !prev_sclk) begin
          pulses++;
          sh = {sh[10:0], shift_dta};
        end
        if (shift_clk) hi_cyc++;
        prev_sclk = shift_clk;
        if (osc_ena) ena_cyc++;
        if (!osc_rst) rlow_cyc++;
        if (clk_source !== rsrc) src_bad++;
        if (res_valid !== 1'b0 || busy !== 1'b1) v_bad++;
        tick();
      end
      chk("valid_rise", res_valid, 1);
      n   = rises(p + 2, p + weff + 1);
      e16 = 16'(n);
      e4  = (n > 15) ? 4'd15 : 4'(n);
      chk("res_count", res_count, e16);
      chk("res_ovf", res_ovf, 0);
      chk("res_count4", res_count4, e4);
      chk("res_ovf4", res_ovf4, (n > 15) ? 1 : 0);
      chk("res_src", res_src, rsrc);
      chk("ena_result", osc_ena, 0);
      if (use_rng) begin
        chk_rng("count_range", int'(res_count), lo, hi);
        chk("ovf4_table", res_ovf4, exp_ovf4);
      end
      st_bad = 0;
      for (int d = 0; d < rdy_delay; d++) begin
        if (res_valid !== 1'b1 || res_count !== e16 || res_count4 !== e4 ||
            res_src !== rsrc || busy !== 1'b1) st_bad++;
        start = (d == rdy_delay / 2);
        tick();
      end
      start = 1'b0;
      if (rdy_delay > 0) chk("hold_stable", st_bad, 0);
      chk("valid_at_ready", res_valid, 1);
      res_ready = 1'b1;
      tick();
      chk("valid_drop", res_valid, 0);
      chk("busy_after_hs", busy, (k == nres - 1) ? 0 : 1);
      res_ready = (rdy_delay == 0);
      p = cyc;
      rsrc = rsrc + 3'd1;
    end
    chk("shift_pulses", pulses, 12);
    chk("shift_high_cycles", hi_cyc, 12 * SHIFT_DIV);
    chk("shifter_model", sh, cfg);
    chk("ena_cycles", ena_cyc, nres * (4 + weff));
    chk("osc_rst_low_cycles", rlow_cyc, nres * weff);
    chk("clk_source_bad", src_bad, 0);
    chk("valid_busy_bad", v_bad, 0);
  endtask

  typedef struct {
    logic [11:0] cfg;
    logic [2:0]  src;
    logic [15:0] win;
    int          half;
    bit          swp;
    int          rdy;
    int          lo;
    int          hi;
    bit          ovf4;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{cfg: 12'hA5C, src: 3'd3, win: 16'd100, half: 5, swp: 1'b0, rdy: 0,  lo: 9,  hi: 11,  ovf4: 1'b0};
    vecs[1] = '{cfg: 12'h5A3, src: 3'd7, win: 16'd200, half: 1, swp: 1'b0, rdy: 3,  lo: 99, hi: 101, ovf4: 1'b1};
    vecs[2] = '{cfg: 12'hFFF, src: 3'd0, win: 16'd0,   half: 0, swp: 1'b0, rdy: 0,  lo: 0,  hi: 0,   ovf4: 1'b0};
    vecs[3] = '{cfg: 12'h001, src: 3'd5, win: 16'd3,   half: 2, swp: SWEEP_BUILD ? 1'b0 : 1'b1, rdy: 50, lo: 0, hi: 1, ovf4: 1'b0};
    vecs[4] = '{cfg: 12'h800, src: 3'd1, win: 16'd16,  half: 1, swp: 1'b0, rdy: 1,  lo: 7,  hi: 9,   ovf4: 1'b0};

    rst = 1'b1; start = 1'b0; sweep = 1'b0; osc_in = 1'b0; res_ready = 1'b0;
    cfg_word = '0; src_sel = '0; win_len = '0;
    repeat (3) tick();
    chk("rst_shift_clk", shift_clk, 0);
    chk("rst_shift_dta", shift_dta, 0);
    chk("rst_clk_source", clk_source, 0);
    chk("rst_osc_ena", osc_ena, 0);
    chk("rst_osc_rst", osc_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_src", res_src, 0);
    chk("rst_res_ovf", res_ovf, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      set_osc(vecs[i].half, 1'b0);
      run_meas(vecs[i].cfg, vecs[i].src, vecs[i].win, vecs[i].swp, vecs[i].rdy,
               1'b1, vecs[i].lo, vecs[i].hi, vecs[i].ovf4);
    end

    // Reset in the 40th SHIFT cycle, then a full reload.
    set_osc(3, 1'b0);
    start = 1'b1; cfg_word = 12'h3C3; src_sel = 3'd6; win_len = 16'd10; res_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_shift_clk", shift_clk, 0);
    chk("midrst_osc_rst", osc_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_clk_source", clk_source, 0);
    chk("midrst_osc_ena", osc_ena, 0);
    tick();
    run_meas(12'h6B9, 3'd2, 16'd12, 1'b0, 0, 1'b0, 0, 0, 1'b0);

`ifdef RO_MEAS_SWEEP_EN
    set_osc(2, 1'b0);
    run_meas(12'hA5C, 3'd5, 16'd20, 1'b1, 2, 1'b0, 0, 0, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) set_osc(0, 1'b1);
      else                           set_osc(int'($urandom_range(1, 7)), 1'b0);
      run_meas(12'($urandom), 3'($urandom), 16'($urandom_range(0, 300)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 1'b0, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ro_meas_ctrl.md
# ro_meas_ctrl

Sequencer for the ring-oscillator test array. It serially loads the 12-bit oscillator configuration shifter and selects one of the eight clock sources. It then opens a fixed gate window on `clk`, counts rising edges of the selected divided oscillator output, and returns the count over a valid/ready handshake. It sits between the on-chip control/readout logic and the oscillator bank's `shift_clk`/`shift_dta`/`clk_source`/`ena` inputs.

## Interface
Parameters:
- `CFG_W`, 12: configuration shifter length in bits.
- `CNT_W`, 16: edge-counter width.
- `WIN_W`, 16: gate-window length width.
- `SHIFT_DIV`, 4: `clk` cycles per `shift_clk` half-period (≥1).

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: pulse; begin measurement (sampled in IDLE only).
- `sweep` in 1: sweep request, sampled with `start` (see Configuration).
- `cfg_word` in CFG_W: shifter contents to load, sampled at `start`.
- `src_sel` in 3: oscillator index, sampled at `start`.
- `win_len` in WIN_W: gate length in `clk` cycles, sampled at `start`; 0 is treated as 1.
- `osc_in` in 1: selected divided oscillator output, asynchronous.
- `shift_clk` out 1: configuration shift clock.
- `shift_dta` out 1: configuration shift data.
- `clk_source` out 3: oscillator select.
- `osc_ena` out 1: oscillator enable.
- `osc_rst` out 1: divider/counter reset, active-high.
- `busy` out 1: high whenever state ≠ IDLE.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_count` out CNT_W: edge count.
- `res_src` out 3: source index of the result.
- `res_ovf` out 1: count saturated.

## Operation
- States: IDLE → SHIFT → SETTLE → GATE → RESULT → IDLE.
- IDLE:
  - `start`=1 latches `cfg_word`, `src_sel` and `win_len`, then moves to SHIFT.
  - `start` is ignored in every other state.
- SHIFT:
  - Shifts out CFG_W bits, MSB first.
  - Per bit: `shift_dta` is set, `shift_clk` is held low for SHIFT_DIV cycles, then high for SHIFT_DIV cycles.
  - After the last bit the downstream shifter equals `cfg_word`, with shifter[CFG_W-1] = `cfg_word`[CFG_W-1].
  - `shift_clk` returns low on exit.
  - `clk_source` is driven with the latched `src_sel` from SHIFT entry onward.
- SETTLE: `osc_ena`=1 and `osc_rst`=1 for 4 cycles; `osc_rst` drops on exit.
- GATE:
  - Runs for `win_len` cycles.
  - Each rising edge of `osc_in` that the edge detector (2-flop sync) reports during GATE increments the count.
  - The count saturates at 2^CNT_W−1 and sets `ovf`.
- RESULT:
  - `osc_ena`=0 and `res_valid`=1.
  - `res_count`, `res_src` and `res_ovf` stay stable until `res_valid && res_ready`, then the block leaves RESULT.
- The count clears on GATE entry.

## Timing
- Reset values:
  - `shift_clk`=0, `shift_dta`=0, `clk_source`=0, `osc_ena`=0, `osc_rst`=1.
  - `busy`=0, `res_valid`=0, `res_count`=0, `res_src`=0, `res_ovf`=0.
  - State is IDLE.
- `start` at cycle t: `busy`=1 at t+1.
- SHIFT lasts CFG_W·2·SHIFT_DIV cycles; this is 96 with defaults.
- Total from `start` to first `res_valid` = 1 + 2·CFG_W·SHIFT_DIV + 4 + max(`win_len`,1) cycles.
- Edge-detect latency is 3 cycles. Edges arriving in the final 3 GATE cycles are not counted (documented measurement bias).
- Handshake:
  - If `res_ready` is already high when `res_valid` rises, the transfer completes in that cycle.
  - IDLE follows in the next cycle, and `start` is accepted there.
- `rst` mid-operation:
  - All outputs return to reset values on the next edge.
  - A partial configuration stays in the shifter; the next `start` rewrites all CFG_W bits.

## Configuration
- `RO_MEAS_SWEEP_EN` defined: `start` with `sweep`=1 runs SHIFT once, then loops SETTLE→GATE→RESULT for sources 0..7 in order.
  - Each source gets its own result handshake.
  - `busy` stays high until source 7's result is accepted.
  - `src_sel` is ignored in sweep mode.
- Undefined: `sweep` is ignored; every `start` measures `src_sel` only.

## Structure
- Package `ro_meas_pkg` holds:
  - the state enum;
  - `SETTLE_CYC`=4;
  - `NUM_SRC`=8;
  - `SYNC_STAGES`=2.
- Sub-module `ro_meas_edge_cnt`: synchronizer, rising-edge detect, clear, and saturating counter with ovf.

## Test plan
- Loading: `cfg_word`=12'hA5C, SHIFT_DIV=4 → 12 `shift_clk` pulses, each 4 cycles high. A model shifter holds 12'hA5C, and `busy` falls only after the handshake.
- Counting: `osc_in` toggles every 5 `clk`, `win_len`=100 → `res_count` = 10±1, `res_ovf`=0, `res_src`=`src_sel`.
- Saturation: CNT_W=4, `osc_in` period 2 cycles, `win_len`=200 → `res_count`=15, `res_ovf`=1.
- Back-pressure: `res_ready` held low for 50 cycles → `res_*` stable and a second `start` is ignored. Then `res_ready`=1 → IDLE on the next cycle.
- Reset: `rst` asserted in cycle 40 of SHIFT → next cycle has `shift_clk`=0, `osc_rst`=1, `busy`=0. A new `start` then completes a full 12-bit load.
- Sweep (`RO_MEAS_SWEEP_EN`): `start` with `sweep`=1 → exactly 12 `shift_clk` pulses, 8 results with `res_src` 0..7 in order, and `busy`=0 after the eighth handshake.
